// File: rtl/fft_frame_sched_pkg.sv
// Shared definitions for the spectrum display path: FSM state encoding,
// default frame geometry and the magnitude scale-and-clamp helper that the
// LCD draw logic reuses.
package fft_frame_sched_pkg;

    localparam int unsigned FFT_N_DEF    = 1024;
    localparam int unsigned KEEP_PTS_DEF = 512;
    localparam int unsigned Y_MAX_DEF    = 480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SKIP,
        ST_PAD
    } state_e;

    // Right-shift a raw FFT magnitude and clamp it to the screen height.
    function automatic logic [15:0] scale_clamp(
        input logic [15:0] mag,
        input logic [3:0]  sh,
        input logic [15:0] y_max
    );
        logic [15:0] shifted;
        shifted = mag >> sh;
        return (shifted > y_max) ? y_max : shifted;
    endfunction

endpackage

// File: rtl/fft_mag_scale.sv
// Registered shift-and-clamp stage feeding the display FIFO write port.
// A pad request writes a zero word regardless of the data input.
module fft_mag_scale
    import fft_frame_sched_pkg::*;
#(
    parameter logic [15:0] Y_MAX = 16'(Y_MAX_DEF)
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_pad,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_shift,
    output logic        out_valid,
    output logic        out_data_unused_n,
    output logic [15:0] out_data
);

    logic        valid_d, valid_q;
    logic [15:0] data_d,  data_q;

    // Next write word: scaled magnitude, zero for padding, held otherwise.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        valid_d = in_valid;
        data_d  = data_q;
        if (in_valid) begin
            data_d = in_pad ? 16'd0 : scale_clamp(in_data, in_shift, Y_MAX);
        end
    end

    // Output register; reset clears the write strobe and the data word.
    always_ff @(posedge clk_50m) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 16'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid         = valid_q;
    assign out_data          = data_q;
    assign out_data_unused_n = 1'b1;

endmodule

// File: rtl/fft_frame_sched.sv
// Frame-level write scheduler between the FFT output stream and the display
// FIFO. Whole frames are admitted only when a full spectrum fits; the first
// KEEP_PTS bins are scaled and clamped, short or aborted frames are padded
// with zeros so the FIFO stays frame-aligned for the LCD-side reader.
module fft_frame_sched
    import fft_frame_sched_pkg::*;
#(
    parameter int unsigned FFT_N      = FFT_N_DEF,
    parameter int unsigned KEEP_PTS   = KEEP_PTS_DEF,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned Y_MAX      = Y_MAX_DEF
) (
    input  logic             clk_50m,
    input  logic             rst,
    input  logic             enable,
    input  logic [3:0]       decim,
    input  logic [3:0]       shift,
    input  logic [15:0]      fft_data,
    input  logic             fft_sop,
    input  logic             fft_eop,
    input  logic             fft_valid,
    input  logic [CNT_W-1:0] fifo_wr_cnt,
    output logic             fifo_wr_req,
    output logic [15:0]      fifo_wr_data,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      drop_cnt,
    output logic             err_short
);

    localparam int unsigned IDX_W = $clog2(FFT_N);

    state_e           state_d, state_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [3:0]       dec_cnt_d, dec_cnt_q;
    logic [3:0]       shift_d, shift_q;
    logic [15:0]      drop_cnt_d, drop_cnt_q;
    logic             frame_done_d, frame_done_q;
    logic             err_short_d, err_short_q;

    logic             wr_en;
    logic             wr_pad;
    logic [3:0]       wr_shift;
    logic             space_ok;
    logic             dec_hit;
    logic             take_frame;
    logic             refuse_frame;
    logic             drop_inc;
    logic             last_keep;
    logic [3:0]       dec_cnt_next;
    logic [IDX_W-1:0] idx_inc;
    logic             scale_unused_n;

    // Admission decision for a frame starting on this beat, plus index helpers.
    always_comb begin
        // The -1 margin plus the whole-frame check absorbs a few cycles of
        // occupancy lag from the FIFO's synchroniser.
        space_ok     = (32'(fifo_wr_cnt) + KEEP_PTS) <= (FIFO_DEPTH - 1);
        dec_hit      = (dec_cnt_q == 4'd0);
        take_frame   = enable && space_ok && dec_hit;
        refuse_frame = enable && dec_hit && !space_ok;
        // Wrapping on >= keeps the counter bounded if decim shrinks mid-run.
        if (!enable) begin
            dec_cnt_next = dec_cnt_q;
        end else if (dec_cnt_q >= decim) begin
            dec_cnt_next = 4'd0;
        end else begin
            dec_cnt_next = dec_cnt_q + 4'd1;
        end
        last_keep = (32'(idx_q) + 32'd1) == KEEP_PTS;
        idx_inc   = (idx_q == IDX_W'(FFT_N - 1)) ? idx_q : idx_q + IDX_W'(1);
    end

    // Frame FSM: next state, bin index, counters and the write request.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dec_cnt_d    = dec_cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        err_short_d  = 1'b0;
        drop_inc     = 1'b0;
        wr_en        = 1'b0;
        wr_pad       = 1'b0;
        wr_shift     = shift_q;

        case (state_q)
            ST_IDLE, ST_SKIP: begin
                if (fft_valid && fft_sop) begin
                    dec_cnt_d = dec_cnt_next;
                    shift_d   = shift;
                    idx_d     = IDX_W'(1);
                    if (take_frame) begin
                        wr_en    = 1'b1;
                        wr_shift = shift;
                        state_d  = ST_CAPTURE;
                    end else begin
                        drop_inc = refuse_frame;
                        state_d  = ST_SKIP;
                    end
                end else if (state_q == ST_SKIP && fft_valid) begin
                    idx_d = idx_inc;
                    if (fft_eop) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_CAPTURE: begin
                if (fft_valid) begin
                    if (fft_sop) begin
                        // Missing eop: the new frame is lost, pad the old one.
                        err_short_d = 1'b1;
                        drop_inc    = 1'b1;
                        state_d     = ST_PAD;
                    end else begin
                        wr_en = 1'b1;
                        idx_d = idx_inc;
                        if (last_keep) begin
                            frame_done_d = 1'b1;
                            if (fft_eop) begin
                                idx_d   = '0;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_SKIP;
                            end
                        end else if (fft_eop) begin
                            err_short_d = 1'b1;
                            state_d     = ST_PAD;
                        end
                    end
                end
            end

            ST_PAD: begin
                wr_en  = 1'b1;
                wr_pad = 1'b1;
                idx_d  = idx_inc;
                if (last_keep) begin
                    frame_done_d = 1'b1;
                    idx_d        = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1
                                                          : drop_cnt_q;
    end

    // State and counter registers; reset abandons any partial frame unpadded.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dec_cnt_q    <= 4'd0;
            shift_q      <= 4'd0;
            drop_cnt_q   <= 16'd0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dec_cnt_q    <= dec_cnt_d;
            shift_q      <= shift_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
        end
    end

    fft_mag_scale #(
        .Y_MAX(16'(Y_MAX))
    ) u_scale (
        .clk_50m          (clk_50m),
        .rst              (rst),
        .in_valid         (wr_en),
        .in_pad           (wr_pad),
        .in_data          (fft_data),
        .in_shift         (wr_shift),
        .out_valid        (fifo_wr_req),
        .out_data_unused_n(scale_unused_n),
        .out_data         (fifo_wr_data)
    );

    assign busy       = (state_q == ST_CAPTURE) || (state_q == ST_PAD);
    assign frame_done = frame_done_q && scale_unused_n;
    assign err_short  = err_short_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed testbench for fft_frame_sched: frame admission, scaling/clamp,
// decimation, padding of short/aborted frames and mid-frame reset.
module tb_fft_frame_sched;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  decim;
    logic [3:0]  shift;
    logic [15:0] fft_data;
    logic        fft_sop;
    logic        fft_eop;
    logic        fft_valid;
    logic [9:0]  fifo_wr_cnt;
    logic        fifo_wr_req;
    logic [15:0] fifo_wr_data;
    logic        busy;
    logic        frame_done;
    logic [15:0] drop_cnt;
    logic        err_short;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    int          fd_pos[$];
    int          err_pos[$];

    fft_frame_sched #(
        .FFT_N     (1024),
        .KEEP_PTS  (512),
        .FIFO_DEPTH(1024),
        .CNT_W     (10),
        .Y_MAX     (480)
    ) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .enable      (enable),
        .decim       (decim),
        .shift       (shift),
        .fft_data    (fft_data),
        .fft_sop     (fft_sop),
        .fft_eop     (fft_eop),
        .fft_valid   (fft_valid),
        .fifo_wr_cnt (fifo_wr_cnt),
        .fifo_wr_req (fifo_wr_req),
        .fifo_wr_data(fifo_wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .drop_cnt    (drop_cnt),
        .err_short   (err_short)
    );

    always #10 clk_50m = ~clk_50m;

    // Record every FIFO write, and the write count at each pulse.
    always @(negedge clk_50m) begin
        if (fifo_wr_req === 1'b1) wr_q.push_back(fifo_wr_data);
        if (frame_done === 1'b1) fd_pos.push_back(wr_q.size());
        if (err_short === 1'b1) err_pos.push_back(wr_q.size());
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_test();
        wr_q.delete();
        exp_q.delete();
        fd_pos.delete();
        err_pos.delete();
    endtask

    task automatic push_data(input int n, input int mul, input int sh);
        int v;
        for (int i = 0; i < n; i++) begin
            v = ((i * mul) & 16'hFFFF) >> sh;
            exp_q.push_back(16'((v > 480) ? 480 : v));
        end
    endtask

    task automatic push_zero(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(16'd0);
    endtask

    task automatic idle(input int n);
        fft_valid = 1'b0;
        fft_sop   = 1'b0;
        fft_eop   = 1'b0;
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    // Drive one frame of len beats with data = beat*mul; optional shift change
    // on beat 1 and an optional one-cycle reset on beat rst_at.
    task automatic send_frame(input int len, input bit with_eop, input int mul,
                              input int shift_mid, input int rst_at);
        for (int i = 0; i < len; i++) begin
            fft_valid = 1'b1;
            fft_sop   = (i == 0);
            fft_eop   = with_eop && (i == len - 1);
            fft_data  = 16'(i * mul);
            if (i == 1 && shift_mid >= 0) shift = 4'(shift_mid);
            rst = (i == rst_at);
            @(posedge clk_50m);
            #1;
            if (i == rst_at) begin
                check("rst_wr_req", 32'(fifo_wr_req), 0);
                check("rst_wr_data", 32'(fifo_wr_data), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_frame_done", 32'(frame_done), 0);
                check("rst_err_short", 32'(err_short), 0);
                check("rst_drop_cnt", 32'(drop_cnt), 0);
            end
        end
        rst       = 1'b0;
        fft_valid = 1'b0;
        fft_sop   = 1'b0;
        fft_eop   = 1'b0;
    endtask

    task automatic check_run(input string tag, input int fd0, input int fd1,
                             input int err0, input int drop);
        int n_fd;
        int bad;
        int first;
        int n;
        n_fd = ((fd0 >= 0) ? 1 : 0) + ((fd1 >= 0) ? 1 : 0);
        check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
        bad   = 0;
        first = 0;
        n     = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (wr_q[i] !== exp_q[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        n_checks++;
        assert (bad == 0) else begin
            n_fail++;
            $error("FAIL %s_data: %0d words differ, first at word %0d observed %0d expected %0d",
                   tag, bad, first, wr_q[first], exp_q[first]);
        end
        check({tag, "_done_count"}, fd_pos.size(), n_fd);
        if (fd0 >= 0 && fd_pos.size() > 0) check({tag, "_done0_at"}, fd_pos[0], fd0);
        if (fd1 >= 0 && fd_pos.size() > 1) check({tag, "_done1_at"}, fd_pos[1], fd1);
        check({tag, "_err_count"}, err_pos.size(), (err0 >= 0) ? 1 : 0);
        if (err0 >= 0 && err_pos.size() > 0) check({tag, "_err_at"}, err_pos[0], err0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), drop);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        decim       = 4'd0;
        shift       = 4'd0;
        fft_data    = 16'd0;
        fft_sop     = 1'b0;
        fft_eop     = 1'b0;
        fft_valid   = 1'b0;
        fifo_wr_cnt = 10'd0;
        repeat (3) @(posedge clk_50m);
        #1;
        check("init_wr_req", 32'(fifo_wr_req), 0);
        check("init_wr_data", 32'(fifo_wr_data), 0);
        check("init_busy", 32'(busy), 0);
        check("init_frame_done", 32'(frame_done), 0);
        check("init_err_short", 32'(err_short), 0);
        check("init_drop_cnt", 32'(drop_cnt), 0);
        rst    = 1'b0;
        enable = 1'b1;
        idle(2);

        // Full frame, data = index: 512 writes of min(idx,480).
        start_test();
        send_frame(1024, 1'b1, 1, -1, -1);
        idle(5);
        push_data(512, 1, 0);
        check_run("basic", 512, -1, -1, 0);
        check("basic_busy_after", 32'(busy), 0);

        // Shift 2 sampled at sop (changed to 0 on beat 1), data = 8*idx.
        start_test();
        shift = 4'd2;
        send_frame(1024, 1'b1, 8, 0, -1);
        idle(5);
        push_data(512, 8, 2);
        check_run("shift", 512, -1, -1, 0);

        // No room: 1023-600 < 512, frame refused and counted.
        start_test();
        fifo_wr_cnt = 10'd600;
        send_frame(1024, 1'b1, 1, -1, -1);
        idle(5);
        check_run("nospace", -1, -1, -1, 1);
        start_test();
        fifo_wr_cnt = 10'd0;
        send_frame(1024, 1'b1, 1, -1, -1);
        idle(5);
        push_data(512, 1, 0);
        check_run("after_nospace", 512, -1, -1, 1);

        // Space boundary: occupancy 512 refused, 511 accepted (eop on word 512).
        start_test();
        fifo_wr_cnt = 10'd512;
        send_frame(512, 1'b1, 1, -1, -1);
        idle(5);
        check_run("edge_512", -1, -1, -1, 2);
        start_test();
        fifo_wr_cnt = 10'd511;
        send_frame(512, 1'b1, 1, -1, -1);
        idle(5);
        push_data(512, 1, 0);
        check_run("edge_511", 512, -1, -1, 2);
        fifo_wr_cnt = 10'd0;

        // Disabled: frame skipped without counting a drop.
        start_test();
        enable = 1'b0;
        send_frame(1024, 1'b1, 1, -1, -1);
        idle(5);
        check_run("disabled", -1, -1, -1, 2);
        enable = 1'b1;

        // Decimation 2 over six back-to-back frames: frames 0 and 3 kept.
        start_test();
        decim = 4'd2;
        repeat (6) send_frame(1024, 1'b1, 1, -1, -1);
        idle(5);
        push_data(512, 1, 0);
        push_data(512, 1, 0);
        check_run("decim", 512, 1024, -1, 2);
        decim = 4'd0;

        // Short frame: eop on beat 99, then 412 zero pad words.
        start_test();
        send_frame(100, 1'b1, 1, -1, -1);
        check("short_busy_in_pad", 32'(busy), 1);
        idle(420);
        push_data(100, 1, 0);
        push_zero(412);
        check_run("short", 512, -1, 100, 2);

        // Missing eop: sop at beat 200 aborts, pads 312, next clean frame kept.
        start_test();
        send_frame(200, 1'b0, 1, -1, -1);
        send_frame(1024, 1'b1, 1, -1, -1);
        idle(5);
        send_frame(1024, 1'b1, 1, -1, -1);
        idle(5);
        push_data(200, 1, 0);
        push_zero(312);
        push_data(512, 1, 0);
        check_run("abort", 512, 1024, 200, 3);

        // One-cycle reset right after write 300; no padding afterwards.
        start_test();
        send_frame(1024, 1'b1, 1, -1, 300);
        idle(5);
        check("rst_partial_words", wr_q.size(), 300);
        check("rst_no_done", fd_pos.size(), 0);
        start_test();
        send_frame(1024, 1'b1, 1, -1, -1);
        idle(5);
        push_data(512, 1, 0);
        check_run("post_rst", 512, -1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
